digit_counter: RTL and testbench
================================

// Module: digit_counter
// PURPOSE
//  Parametrised single-digit time counter for the alarm clock datapath: one instance per
//  display digit (sec/min units and tens, hour units and tens). Counts up or down, wraps
//  at a static or runtime limit, and emits carry/borrow to chain with the next digit.
//  Adds a bounds-checked parallel load and clamps the value when the limit drops below it
//  (hour units under 24h mode).
// PARAMETERS
//  WIDTH      4   digit register width in bits
//  MAX_VAL    5   static terminal value; must be < 2**WIDTH (elaboration-time assert)
//  RESET_VAL  0   value loaded on reset; must be <= MAX_VAL
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      synchronous, active-high
//  set         in   1      load new_val this cycle
//  new_val     in   WIDTH  value for set
//  inc         in   1      count up one (chain: previous digit's carry_out)
//  dec         in   1      count down one (chain: previous digit's borrow_out)
//  limit       in   WIDTH  runtime terminal value; eff_max = min(MAX_VAL, limit)
//  Q           out  WIDTH  current digit value
//  at_max      out  1      Q == eff_max (combinational)
//  at_min      out  1      Q == 0 (combinational)
//  carry_out   out  1      inc wraps this cycle (combinational)
//  borrow_out  out  1      dec wraps this cycle (combinational)
//  set_err     out  1      registered, 1-cycle pulse: rejected set (new_val > eff_max)
// BEHAVIOUR
//  - Reset: Q = RESET_VAL, set_err = 0 on the next edge. Reset wins over every input.
//  - Priority per edge: reset > set > clamp > inc/dec > hold.
//  - set, new_val <= eff_max: Q <= new_val; inc/dec ignored that cycle; no carry/borrow.
//  - set, new_val > eff_max: Q holds, set_err = 1 next cycle; inc/dec ignored that cycle.
//  - Clamp: if Q > eff_max (limit lowered) and no reset/set: Q <= 0 next edge, no carry;
//    inc/dec ignored that cycle.
//  - inc only: Q <= (Q == eff_max) ? 0 : Q+1. dec only: Q <= (Q == 0) ? eff_max : Q-1.
//  - inc && dec together: Q holds, carry_out = borrow_out = 0.
//  - carry_out = inc & ~dec & at_max & ~set & ~reset; borrow_out symmetric, with at_min.
//    Same-cycle combinational: chained digit samples it on the same edge; 0 latency.
//  - Wrap compare uses eff_max (WIDTH bits, unsigned); with limit = 0 the digit stays 0
//    and every inc/dec produces carry/borrow.
//  - Outputs at_max/at_min track Q and limit combinationally; valid from the first cycle
//    after reset.
// STRUCTURE
//  - Shared package clock_pkg: DIGIT_W = 4; per-digit limits SEC_TENS_MAX = 5,
//    MIN_TENS_MAX = 5, UNITS_MAX = 9, HR_TENS_MAX_24 = 2, HR_UNITS_MAX_LOW = 3;
//    a digit_op_e enum {OP_HOLD, OP_LOAD, OP_CLAMP, OP_INC, OP_DEC} for the next-state select.
//  - One sub-module: regnbit (WIDTH-bit load-enable register with sync reset value). This
//    block keeps the next-state mux, eff_max logic, compares, and the set_err flop.
// TESTING
//  1 reset with Q=3 -> next cycle Q=RESET_VAL(0), set_err=0, at_min=1.
//  2 MAX_VAL=5, Q=5, inc=1 -> carry_out=1 same cycle, Q=0 next; Q=0, dec=1 ->
//    borrow_out=1, Q=5 next.
//  3 MAX_VAL=9, limit=3, set new_val=7 -> Q unchanged, set_err=1 one cycle;
//    set new_val=3 -> Q=3, set_err=0.
//  4 MAX_VAL=9, Q=7, limit dropped 9->3 -> Q=0 next cycle, carry_out=0 throughout.
//  5 Q=5 (MAX 5), inc=dec=1 -> Q holds 5, no carry/borrow; set=1 with inc=1 at Q=5 ->
//    Q=new_val, carry_out=0.
//  6 Chain two instances (units MAX 9, tens MAX 5), 60 incs from 00 -> reads 00,
//    tens carry_out=1 exactly on the 60th inc; reset asserted mid-sequence -> both 0 next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time datapath.
// Purpose : digit width, per-digit terminal values and the next-state
//           selector used by every digit_counter instance.
// Ports   : none (package).
package clock_pkg;

   localparam int DIGIT_W          = 4;
   localparam int SEC_TENS_MAX     = 5;
   localparam int MIN_TENS_MAX     = 5;
   localparam int UNITS_MAX        = 9;
   localparam int HR_TENS_MAX_24   = 2;
   localparam int HR_UNITS_MAX_LOW = 3;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_LOAD,
      OP_CLAMP,
      OP_INC,
      OP_DEC
   } digit_op_e;

endpackage

// File: rtl/digit_counter_regnbit.sv
// regnbit: WIDTH-bit register with load enable and synchronous reset value.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high; loads RESET_VAL
//   en     in   1      load d on this edge
//   d      in   WIDTH  next value
//   q      out  WIDTH  stored value
module regnbit #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= RESET_VAL;
      end else if (en) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/digit_counter.sv
// digit_counter: one display digit of the alarm clock. Counts up or down,
// wraps at min(MAX_VAL, limit), loads a bounds-checked value, and clamps to 0
// when the runtime limit falls below the current value. carry_out/borrow_out
// are combinational so a chained digit advances on the same edge.
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   set         in   1      load new_val this cycle
//   new_val     in   WIDTH  value for set
//   inc         in   1      count up one
//   dec         in   1      count down one
//   limit       in   WIDTH  runtime terminal value
//   Q           out  WIDTH  current digit value
//   at_max      out  1      Q == eff_max
//   at_min      out  1      Q == 0
//   carry_out   out  1      inc wraps this cycle
//   borrow_out  out  1      dec wraps this cycle
//   set_err     out  1      one-cycle pulse after a rejected set
module digit_counter
   import clock_pkg::*;
#(
   parameter int WIDTH     = DIGIT_W,
   parameter int MAX_VAL   = 5,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic [WIDTH-1:0] new_val,
   input  logic             inc,
   input  logic             dec,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] Q,
   output logic             at_max,
   output logic             at_min,
   output logic             carry_out,
   output logic             borrow_out,
   output logic             set_err
);

   if (MAX_VAL >= (1 << WIDTH) || MAX_VAL < 0 || RESET_VAL < 0 || RESET_VAL > MAX_VAL)
   begin : g_param_check
      $error("digit_counter: MAX_VAL must fit WIDTH and RESET_VAL must be in 0..MAX_VAL");
   end

   localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] eff_max;
   logic [WIDTH-1:0] q_d;
   logic             q_en;
   logic             set_ok;
   logic             clamp;
   logic             set_err_q;
   logic             set_err_d;
   digit_op_e        op;

   assign eff_max = (limit < MAX_W) ? limit : MAX_W;

   assign at_max = (Q == eff_max);
   assign at_min = (Q == '0);
   assign set_ok = (new_val <= eff_max);
   // Q can only exceed eff_max after the runtime limit has been lowered.
   assign clamp  = (Q > eff_max);

   assign carry_out  = inc & ~dec & at_max & ~set & ~reset;
   assign borrow_out = dec & ~inc & at_min & ~set & ~reset;

   // Priority: set > clamp > inc/dec > hold (reset is handled in the register).
   always_comb begin
      op = OP_HOLD;
      if (set) begin
         op = set_ok ? OP_LOAD : OP_HOLD;
      end else if (clamp) begin
         op = OP_CLAMP;
      end else if (inc && !dec) begin
         op = OP_INC;
      end else if (dec && !inc) begin
         op = OP_DEC;
      end
   end

   always_comb begin
      q_d  = Q;
      q_en = 1'b1;
      case (op)
         OP_LOAD:  q_d = new_val;
         OP_CLAMP: q_d = '0;
         OP_INC:   q_d = at_max ? '0 : Q + WIDTH'(1);
         OP_DEC:   q_d = at_min ? eff_max : Q - WIDTH'(1);
         default: begin
            q_d  = Q;
            q_en = 1'b0;
         end
      endcase
   end

   regnbit #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RST_W)
   ) u_reg (
      .clk  (clk),
      .reset(reset),
      .en   (q_en),
      .d    (q_d),
      .q    (Q)
   );

   assign set_err_d = set & ~set_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         set_err_q <= 1'b0;
      end else begin
         set_err_q <= set_err_d;
      end
   end

   assign set_err = set_err_q;

endmodule

// File: tb/tb_digit_counter.sv
// Directed bench for digit_counter: a MAX 5 digit, a MAX 9 digit, and a
// units(9)/tens(5) chain.
module tb_digit_counter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // MAX_VAL = 5
   logic       set_a, inc_a, dec_a;
   logic [3:0] nv_a, lim_a, q_a;
   logic       amax_a, amin_a, co_a, bo_a, se_a;
   // MAX_VAL = 9
   logic       set_b, inc_b, dec_b;
   logic [3:0] nv_b, lim_b, q_b;
   logic       amax_b, amin_b, co_b, bo_b, se_b;
   // chain: units MAX 9 -> tens MAX 5
   logic       inc_u;
   logic [3:0] q_u, q_t;
   logic       amax_u, amin_u, co_u, bo_u, se_u;
   logic       amax_t, amin_t, co_t, bo_t, se_t;
   logic       zero1 = 1'b0;
   logic [3:0] zero4 = 4'd0;
   logic [3:0] lim_f = 4'hF;

   int n_cmp = 0;
   int n_bad = 0;

   digit_counter #(.WIDTH(4), .MAX_VAL(5), .RESET_VAL(0)) dut (
      .clk(clk), .reset(rst), .set(set_a), .new_val(nv_a), .inc(inc_a), .dec(dec_a),
      .limit(lim_a), .Q(q_a), .at_max(amax_a), .at_min(amin_a), .carry_out(co_a),
      .borrow_out(bo_a), .set_err(se_a));

   digit_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dut9 (
      .clk(clk), .reset(rst), .set(set_b), .new_val(nv_b), .inc(inc_b), .dec(dec_b),
      .limit(lim_b), .Q(q_b), .at_max(amax_b), .at_min(amin_b), .carry_out(co_b),
      .borrow_out(bo_b), .set_err(se_b));

   digit_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_units (
      .clk(clk), .reset(rst), .set(zero1), .new_val(zero4), .inc(inc_u), .dec(zero1),
      .limit(lim_f), .Q(q_u), .at_max(amax_u), .at_min(amin_u), .carry_out(co_u),
      .borrow_out(bo_u), .set_err(se_u));

   digit_counter #(.WIDTH(4), .MAX_VAL(5), .RESET_VAL(0)) u_tens (
      .clk(clk), .reset(rst), .set(zero1), .new_val(zero4), .inc(co_u), .dec(zero1),
      .limit(lim_f), .Q(q_t), .at_max(amax_t), .at_min(amin_t), .carry_out(co_t),
      .borrow_out(bo_t), .set_err(se_t));

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int carries;
   int last_carry;

   initial begin
      rst = 1'b1;
      set_a = 0; inc_a = 0; dec_a = 0; nv_a = 0; lim_a = 4'hF;
      set_b = 0; inc_b = 0; dec_b = 0; nv_b = 0; lim_b = 4'hF;
      inc_u = 0;
      step();
      step();
      rst = 1'b0;

      // 1: reset from Q=3, with a competing set
      set_a = 1; nv_a = 3;
      step();
      set_a = 0;
      check_val("load3", q_a, 3);
      rst = 1; set_a = 1; nv_a = 4; inc_a = 1;
      step();
      rst = 0; set_a = 0; inc_a = 0;
      #1;
      check_val("rst_q", q_a, 0);
      check_val("rst_set_err", se_a, 0);
      check_val("rst_at_min", amin_a, 1);

      // 2: wrap up and down at MAX 5
      set_a = 1; nv_a = 2;
      step();
      set_a = 0; inc_a = 1;
      #1;
      check_val("inc_mid_carry", co_a, 0);
      step();
      check_val("inc_mid_q", q_a, 3);
      inc_a = 0; set_a = 1; nv_a = 5;
      step();
      set_a = 0; inc_a = 1;
      #1;
      check_val("wrap_carry", co_a, 1);
      check_val("wrap_at_max", amax_a, 1);
      step();
      inc_a = 0;
      check_val("wrap_q", q_a, 0);
      dec_a = 1;
      #1;
      check_val("wrap_borrow", bo_a, 1);
      step();
      dec_a = 0;
      check_val("borrow_q", q_a, 5);

      // 5: inc and dec together hold; set beats inc
      inc_a = 1; dec_a = 1;
      #1;
      check_val("both_carry", co_a, 0);
      check_val("both_borrow", bo_a, 0);
      step();
      inc_a = 0; dec_a = 0;
      check_val("both_q", q_a, 5);
      set_a = 1; nv_a = 2; inc_a = 1;
      #1;
      check_val("set_inc_carry", co_a, 0);
      step();
      set_a = 0; inc_a = 0;
      check_val("set_inc_q", q_a, 2);

      // 3: rejected and accepted set under limit 3
      lim_b = 3; set_b = 1; nv_b = 7;
      step();
      set_b = 0;
      check_val("rej_q", q_b, 0);
      check_val("rej_err", se_b, 1);
      step();
      check_val("rej_err_pulse", se_b, 0);
      set_b = 1; nv_b = 3;
      step();
      set_b = 0;
      check_val("acc_q", q_b, 3);
      check_val("acc_err", se_b, 0);

      // 4: limit lowered below Q clamps to 0, inc ignored, no carry
      lim_b = 9; set_b = 1; nv_b = 7;
      step();
      set_b = 0;
      check_val("pre_clamp_q", q_b, 7);
      lim_b = 3; inc_b = 1;
      #1;
      check_val("clamp_carry", co_b, 0);
      check_val("clamp_at_max", amax_b, 0);
      step();
      inc_b = 0;
      check_val("clamp_q", q_b, 0);
      check_val("clamp_carry_after", co_b, 0);

      // limit 0: digit pinned at 0, every inc/dec wraps
      lim_b = 0; inc_b = 1;
      #1;
      check_val("lim0_carry", co_b, 1);
      step();
      inc_b = 0;
      check_val("lim0_inc_q", q_b, 0);
      dec_b = 1;
      #1;
      check_val("lim0_borrow", bo_b, 1);
      step();
      dec_b = 0;
      check_val("lim0_dec_q", q_b, 0);

      // 6: chained 60 increments
      carries = 0;
      last_carry = -1;
      for (int i = 0; i < 60; i++) begin
         inc_u = 1;
         #1;
         if (co_t) begin
            carries++;
            last_carry = i;
         end
         step();
      end
      inc_u = 0;
      check_val("chain_units", q_u, 0);
      check_val("chain_tens", q_t, 0);
      check_val("chain_carries", carries, 1);
      check_val("chain_carry_at", last_carry, 59);
      for (int i = 0; i < 23; i++) begin
         inc_u = 1;
         step();
      end
      check_val("chain23_units", q_u, 3);
      check_val("chain23_tens", q_t, 2);
      rst = 1;
      step();
      rst = 0; inc_u = 0;
      check_val("chain_rst_units", q_u, 0);
      check_val("chain_rst_tens", q_t, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
